// File: rtl/arm_imm_encoder_pkg.sv
// Shared definitions for the operand2 rotated-immediate encoder and decode path.
// imm12 layout matches instruction bits 11:0: rot4 in 11:8, imm8 in 7:0.
package arm_imm_encoder_pkg;

    localparam int DATA_W    = 32;
    localparam int IMM8_W    = 8;
    localparam int ROT_W     = 4;
    localparam int IMM12_W   = 12;
    localparam int ROT_STEPS = 16;

    localparam int IMM12_IMM8_LSB = 0;
    localparam int IMM12_IMM8_MSB = 7;
    localparam int IMM12_ROT_LSB  = 8;
    localparam int IMM12_ROT_MSB  = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef struct packed {
        logic [ROT_W-1:0]  rot;
        logic [IMM8_W-1:0] imm8;
    } imm12_t;

    // Shifter-side decode: ROR(zero-extended imm8, 2*rot).
    function automatic logic [DATA_W-1:0] imm12_decode(input imm12_t f);
        logic [DATA_W-1:0]   ext;
        logic [2*DATA_W-1:0] dbl;
        logic [4:0]          shamt;
        ext   = {{(DATA_W-IMM8_W){1'b0}}, f.imm8};
        dbl   = {ext, ext};
        shamt = {f.rot, 1'b0};
        return dbl[shamt +: DATA_W];
    endfunction

endpackage

// File: rtl/arm_imm_encoder_match.sv
// One-candidate rotated-immediate test: rotates the operand left by 2*rot and
// reports whether the result fits in the low 8 bits.
module arm_imm_match
    import arm_imm_encoder_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]      operand,
    input  logic [ROT_W-1:0]  rot,
    output logic              match,
    output logic [IMM8_W-1:0] imm8
);

    logic [4:0]     shamt;
    logic [5:0]     base;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   cand;

    // ROL by s is the N-bit window of {operand, operand} starting at N-s.
    assign shamt = {rot, 1'b0};
    assign base  = 6'(N) - {1'b0, shamt};
    assign dbl   = {operand, operand};
    assign cand  = dbl[base +: N];

    assign match = (cand[N-1:IMM8_W] == '0);
    assign imm8  = cand[IMM8_W-1:0];

endmodule

// File: rtl/arm_imm_encoder.sv
// Iterative operand2 immediate encoder: one rotation per cycle, optional
// second pass on the inverted constant for MOV/MVN and AND/BIC substitution.
module arm_imm_encoder
    import arm_imm_encoder_pkg::*;
#(
    parameter int N         = 32,
    parameter int ROT_STEPS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N-1:0]       value,
    input  logic               allow_invert,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               inverted,
    output logic [IMM12_W-1:0] imm12
);

    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_STEPS - 1);

    state_e            state_q,    state_d;
    logic [ROT_W-1:0]  rot_q,      rot_d;
    logic              pass_q,     pass_d;
    logic [N-1:0]      operand_q,  operand_d;
    logic              inv_en_q,   inv_en_d;
    logic              found_q,    found_d;
    logic              inverted_q, inverted_d;
    imm12_t            imm12_q,    imm12_d;

    logic              match;
    logic [IMM8_W-1:0] imm8;

    arm_imm_match #(.N(N)) u_match (
        .operand (operand_q),
        .rot     (rot_q),
        .match   (match),
        .imm8    (imm8)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a latch behind.
        state_d    = state_q;
        rot_d      = rot_q;
        pass_d     = pass_q;
        operand_d  = operand_q;
        inv_en_d   = inv_en_q;
        found_d    = found_q;
        inverted_d = inverted_q;
        imm12_d    = imm12_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    operand_d  = value;
                    inv_en_d   = allow_invert;
                    rot_d      = '0;
                    pass_d     = 1'b0;
                    found_d    = 1'b0;
                    inverted_d = 1'b0;
                    imm12_d    = '0;
                    state_d    = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                // Smallest rotation wins; pass 0 is exhausted before pass 1.
                if (match) begin
                    imm12_d.rot  = rot_q;
                    imm12_d.imm8 = imm8;
                    found_d      = 1'b1;
                    inverted_d   = pass_q;
                    state_d      = ST_DONE;
                end else if (rot_q != ROT_LAST) begin
                    rot_d = rot_q + 1'b1;
                end else if (!pass_q && inv_en_q) begin
                    operand_d = ~operand_q;
                    rot_d     = '0;
                    pass_d    = 1'b1;
                end else begin
                    found_d = 1'b0;
                    imm12_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values of the others.
        if (reset) begin
            state_q    <= ST_IDLE;
            rot_q      <= '0;
            pass_q     <= 1'b0;
            operand_q  <= '0;
            inv_en_q   <= 1'b0;
            found_q    <= 1'b0;
            inverted_q <= 1'b0;
            imm12_q    <= '0;
        end else begin
            state_q    <= state_d;
            rot_q      <= rot_d;
            pass_q     <= pass_d;
            operand_q  <= operand_d;
            inv_en_q   <= inv_en_d;
            found_q    <= found_d;
            inverted_q <= inverted_d;
            imm12_q    <= imm12_d;
        end
    end

    assign busy     = (state_q == ST_SEARCH);
    assign done     = (state_q == ST_DONE);
    assign found    = found_q;
    assign inverted = inverted_q;
    assign imm12    = imm12_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Directed and randomized checks of arm_imm_encoder: results, done timing,
// busy window, ignored starts and synchronous reset abort.
module tb_arm_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        allow_invert;
    logic        busy;
    logic        done;
    logic        found;
    logic        inverted;
    logic [11:0] imm12;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic        found;
        logic        inverted;
        logic [11:0] imm12;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    arm_imm_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .value        (value),
        .allow_invert (allow_invert),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .inverted     (inverted),
        .imm12        (imm12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int sh);
        if (sh == 0) return x;
        return (x >> sh) | (x << (32 - sh));
    endfunction

    function automatic exp_t mk(input logic f, input logic inv, input logic [11:0] imm, input int cyc);
        exp_t e;
        e.found = f; e.inverted = inv; e.imm12 = imm; e.done_cyc = cyc;
        return e;
    endfunction

    // Brute-force reference: search every (rot, imm8) whose decode equals the target.
    function automatic exp_t model(input logic [31:0] v, input logic inv);
        exp_t e;
        logic [31:0] tgt;
        e = mk(1'b0, 1'b0, 12'h000, inv ? 33 : 17);
        for (int p = 0; p < 2; p++) begin
            if (p == 1 && !inv) break;
            tgt = (p == 1) ? ~v : v;
            for (int r = 0; r < 16; r++)
                for (int i = 0; i < 256; i++)
                    if (!e.found && ror32(32'(i), 2 * r) == tgt) begin
                        e.found    = 1'b1;
                        e.inverted = (p == 1);
                        e.imm12    = {4'(r), 8'(i)};
                        e.done_cyc = 2 + 16 * p + r;
                    end
        end
        return e;
    endfunction

    // Drives one start (cycle 0 = accept edge), then tracks busy/done up to a bounded budget.
    task automatic do_search(input logic [31:0] v, input logic inv, input exp_t e, input int glitch_cyc);
        int   busy_cnt;
        bit   seen;
        exp_t got;
        @(negedge clk);
        start = 1'b1; value = v; allow_invert = inv;
        sb.push_back(e);
        @(posedge clk);
        busy_cnt = 0;
        seen     = 1'b0;
        got      = e;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            start        = (cyc == glitch_cyc);
            value        = (cyc == glitch_cyc) ? 32'h0000_00AA : v;
            allow_invert = inv;
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                got  = sb.pop_front();
                chk("found",    32'(found),    32'(got.found));
                chk("inverted", 32'(inverted), 32'(got.inverted));
                chk("imm12",    32'(imm12),    32'(got.imm12));
                chk("done_cyc", 32'(cyc),      32'(got.done_cyc));
                chk("busy_cnt", 32'(busy_cnt), 32'(got.done_cyc - 1));
            end
        end
        if (!seen) begin
            chk("done_timeout", 32'(seen), 32'd1);
            got = sb.pop_front();
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse",  32'(done),  32'd0);
        chk("idle_after",  32'(busy),  32'd0);
        chk("found_held",  32'(found), 32'(got.found));
        chk("imm12_held",  32'(imm12), 32'(got.imm12));
    endtask

    initial begin
        int          dones;
        logic [31:0] v;
        logic        inv;

        reset = 1'b1; start = 1'b0; value = '0; allow_invert = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_found",    32'(found),    32'd0);
        chk("rst_inverted", 32'(inverted), 32'd0);
        chk("rst_imm12",    32'(imm12),    32'd0);
        reset = 1'b0;

        do_search(32'h0000_00FF, 1'b0, mk(1'b1, 1'b0, 12'h0FF, 2), 0);
        do_search(32'hFF00_0000, 1'b0, mk(1'b1, 1'b0, 12'h4FF, 6), 0);
        chk("decode_4FF", ror32({24'h0, imm12[7:0]}, 2 * int'(imm12[11:8])), 32'hFF00_0000);
        do_search(32'h0000_03FC, 1'b0, mk(1'b1, 1'b0, 12'hFFF, 17), 0);
        do_search(32'hFFFF_FF00, 1'b1, mk(1'b1, 1'b1, 12'h0FF, 18), 3);
        do_search(32'hFFFF_FF00, 1'b0, mk(1'b0, 1'b0, 12'h000, 17), 17);
        do_search(32'h0000_0101, 1'b1, mk(1'b0, 1'b0, 12'h000, 33), 0);
        do_search(32'h0000_0000, 1'b0, mk(1'b1, 1'b0, 12'h000, 2), 0);

        // Reset sampled at cycle 5 of a long search must abort it without a done pulse.
        dones = 0;
        @(negedge clk);
        start = 1'b1; value = 32'h0000_0101; allow_invert = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dones++;
            if (c == 5) reset = 1'b1;
        end
        @(negedge clk);
        if (done) dones++;
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_found", 32'(found), 32'd0);
        chk("abort_imm12", 32'(imm12), 32'd0);
        chk("abort_dones", 32'(dones), 32'd0);
        reset = 1'b0;
        do_search(32'h0000_3FC0, 1'b0, model(32'h0000_3FC0, 1'b0), 0);

        for (int k = 0; k < 6; k++) begin
            v   = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
            if (k % 2 == 1) v = ~v;
            inv = (k % 3 != 0);
            do_search(v, inv, model(v, inv), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
